mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage
Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, reset: all state clears while reset=0, independent of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 AluRes_i  input  32  EX/MEM ALU result, used as memory byte address or writeback value.
REQ-005 WrData_i  input  32  EX/MEM store data.
REQ-006 PC_i  input  32  EX/MEM instruction PC; PC_i+4 is the link value.
REQ-007 MemWr_i  input  1  store request.
REQ-008 MemtoReg_i  input  2  writeback select: 00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as 00).
REQ-009 RegWr_i  input  1  register-write enable.
REQ-010 Rf_i  input  5  destination register.
REQ-011 Ins_i  input  32  instruction word, passed through.
REQ-012 dmem_ready  input  1  memory accepts/completes the current request this cycle.
REQ-013 dmem_rdata  input  32  load data, valid when dmem_ready=1.
REQ-014 dmem_req  output  1  memory request valid.
REQ-015 dmem_we  output  1  1=store, 0=load.
REQ-016 dmem_addr  output  32  word-aligned byte address (AluRes_i).
REQ-017 dmem_wdata  output  32  store data (WrData_i).
REQ-018 Stall_o  output  1  freeze upstream stages; upstream holds all *_i stable while 1.
REQ-019 AddrErr_o  output  1  one-cycle registered pulse: misaligned access dropped.
REQ-020 WbData_o  output  32  registered writeback value.
REQ-021 RegWr_o / Rf_o / Ins_o  output  1/5/32  registered MEM/WB control, one output line each.
Function
REQ-022 Memory op (memop) = MemWr_i or MemtoReg_i==01; misaligned = memop and AluRes_i[1:0]!=00.
REQ-023 FSM states IDLE, WAIT; reset state IDLE.
REQ-024 IDLE: aligned memop -> dmem_req=1 combinationally; dmem_ready=1 -> complete this cycle, stay IDLE; dmem_ready=0 -> go to WAIT.
REQ-025 WAIT: dmem_req=1 with identical addr/we/wdata (from held inputs); dmem_ready=1 -> complete, go IDLE; else stay WAIT, no timeout.
REQ-026 Stall_o = aligned memop and dmem_ready=0, in either state; zero-wait memory gives zero stall cycles.
REQ-027 dmem_req SHALL never be asserted for a misaligned address or a non-memop; dmem_we=MemWr_i, else 0.
REQ-028 On completion (non-memop same cycle; memop on dmem_ready edge) the MEM/WB register SHALL load RegWr_i, Rf_i, Ins_i and WbData = AluRes_i / dmem_rdata / PC_i+4 per MemtoReg_i; latency exactly 1 clk after completion.
REQ-029 Every cycle with Stall_o=1 SHALL load a bubble: RegWr_o=0, Rf_o=0, Ins_o=0, WbData_o=0.
REQ-030 Misaligned memop: no request, no stall, bubble loaded, AddrErr_o=1 next cycle for one cycle.
REQ-031 PC_i+4 wraps modulo 2^32; dmem_rdata is ignored when dmem_ready=0.
Reset
REQ-032 Reset SHALL force FSM to IDLE, all registered outputs (WbData_o, RegWr_o, Rf_o, Ins_o, AddrErr_o) to 0; combinational dmem_req/Stall_o SHALL read 0 while reset=0.
REQ-033 Reset during WAIT SHALL abandon the request; no completion is recorded after release.
Structure
REQ-034 Shared package SHALL hold MemtoReg encodings (WB_ALU=00, WB_MEM=01, WB_PC4=10) and the FSM state type.
REQ-035 The MEM/WB pipeline register SHALL be a sub-module named mem_wb_reg with a bubble input.
Verification
REQ-036 ALU op AluRes_i=0x1234, MemtoReg=00, RegWr=1, Rf=5 -> next cycle WbData_o=0x1234, Rf_o=5, RegWr_o=1, Stall_o never 1.
REQ-037 Load addr 0x100, dmem_ready held 0 for 3 cycles then 1 with rdata 0xDEADBEEF -> Stall_o=1 for 3 cycles, 3 bubbles, then WbData_o=0xDEADBEEF.
REQ-038 Store addr 0x200 data 0x55AA, dmem_ready=1 immediately -> dmem_req=1, dmem_we=1, no stall, RegWr_o=0.
REQ-039 Load addr 0x102 -> dmem_req stays 0, AddrErr_o pulses once, bubble loaded.
REQ-040 reset=0 asserted while in WAIT -> outputs 0, FSM IDLE; jal with PC_i=0xFFFFFFFC -> WbData_o=0x00000000.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: writeback select encodings, FSM state
// type and the MEM/WB payload layout.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic        reg_wr;
        logic [4:0]  rf;
        logic [31:0] ins;
        logic [31:0] wb_data;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

    // The reserved encoding 2'b11 falls through to the ALU result.
    function automatic logic [31:0] wb_select(
        input logic [1:0]  sel,
        input logic [31:0] alu_res,
        input logic [31:0] rdata,
        input logic [31:0] pc
    );
        logic [31:0] res;
        case (sel)
            WB_MEM:  res = rdata;
            WB_PC4:  res = pc + 32'd4;
            default: res = alu_res;
        endcase
        return res;
    endfunction

    function automatic logic is_memop(
        input logic       mem_wr,
        input logic [1:0] sel
    );
        return mem_wr | (sel == WB_MEM);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads an all-zero payload.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= MEMWB_BUBBLE;
        end else if (bubble) begin
            q <= MEMWB_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to data memory, stalls upstream until
// the memory completes, and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AluRes_i,
    input  logic [31:0] WrData_i,
    input  logic [31:0] PC_i,
    input  logic        MemWr_i,
    input  logic [1:0]  MemtoReg_i,
    input  logic        RegWr_i,
    input  logic [4:0]  Rf_i,
    input  logic [31:0] Ins_i,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        Stall_o,
    output logic        AddrErr_o,
    output logic [31:0] WbData_o,
    output logic        RegWr_o,
    output logic [4:0]  Rf_o,
    output logic [31:0] Ins_o
);

    state_e state_q;
    logic   memop;
    logic   misaligned;
    logic   aligned_memop;
    logic   bubble;
    memwb_t wb_d;
    memwb_t wb_q;

    always_comb begin
        memop         = is_memop(MemWr_i, MemtoReg_i);
        misaligned    = memop & (AluRes_i[1:0] != 2'b00);
        aligned_memop = memop & ~misaligned;
    end

    // Upstream holds its outputs during a stall, so the request in WAIT is
    // rebuilt from the same inputs rather than from a captured copy.
    always_comb begin
        dmem_req   = reset & aligned_memop;
        dmem_we    = dmem_req & MemWr_i;
        dmem_addr  = AluRes_i;
        dmem_wdata = WrData_i;
        Stall_o    = dmem_req & ~dmem_ready;
        bubble     = Stall_o | misaligned;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (aligned_memop && !dmem_ready) state_q <= ST_WAIT;
                ST_WAIT: if (dmem_ready || !aligned_memop) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AddrErr_o <= 1'b0;
        end else begin
            AddrErr_o <= misaligned;
        end
    end

    always_comb begin
        wb_d.reg_wr  = RegWr_i;
        wb_d.rf      = Rf_i;
        wb_d.ins     = Ins_i;
        wb_d.wb_data = wb_select(MemtoReg_i, AluRes_i, dmem_rdata, PC_i);
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .reset  (reset),
        .bubble (bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    always_comb begin
        WbData_o = wb_q.wb_data;
        RegWr_o  = wb_q.reg_wr;
        Rf_o     = wb_q.rf;
        Ins_o    = wb_q.ins;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle reference model plus literal checks.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] AluRes_i = '0, WrData_i = '0, PC_i = '0, Ins_i = '0, dmem_rdata = '0;
    logic        MemWr_i = 1'b0, RegWr_i = 1'b0, dmem_ready = 1'b0;
    logic [1:0]  MemtoReg_i = 2'b00;
    logic [4:0]  Rf_i = '0;
    logic        dmem_req, dmem_we, Stall_o, AddrErr_o, RegWr_o;
    logic [31:0] dmem_addr, dmem_wdata, WbData_o, Ins_o;
    logic [4:0]  Rf_o;

    int checks = 0;
    int passed = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .AluRes_i(AluRes_i), .WrData_i(WrData_i), .PC_i(PC_i),
        .MemWr_i(MemWr_i), .MemtoReg_i(MemtoReg_i), .RegWr_i(RegWr_i),
        .Rf_i(Rf_i), .Ins_i(Ins_i),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .Stall_o(Stall_o), .AddrErr_o(AddrErr_o),
        .WbData_o(WbData_o), .RegWr_o(RegWr_o), .Rf_o(Rf_o), .Ins_o(Ins_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: what the stage must do with the inputs present this cycle.
    function automatic bit m_is_mem();
        return MemWr_i || MemtoReg_i == 2'b01;
    endfunction
    function automatic bit m_misaligned();
        return m_is_mem() && (AluRes_i % 4 != 0);
    endfunction
    function automatic bit m_req();
        return reset && m_is_mem() && !m_misaligned();
    endfunction

    // Combinational outputs, sampled mid low phase.
    always @(negedge clk) begin
        #2;
        chk("m_req", 32'(dmem_req), 32'(m_req()));
        chk("m_we", 32'(dmem_we), 32'(m_req() && MemWr_i));
        chk("m_stall", 32'(Stall_o), 32'(m_req() && !dmem_ready));
        if (m_req()) begin
            chk("m_addr", dmem_addr, AluRes_i);
            chk("m_wdata", dmem_wdata, WrData_i);
        end
    end

    // Registered outputs: predict at the edge, compare shortly after.
    always @(posedge clk) begin
        logic        e_rw, e_err;
        logic [4:0]  e_rf;
        logic [31:0] e_ins, e_wb;
        bit          load_result;
        e_rw = 0; e_rf = 0; e_ins = 0; e_wb = 0; e_err = 0;
        if (reset) begin
            e_err = m_misaligned();
            load_result = !m_misaligned() && !(m_req() && !dmem_ready);
            if (load_result) begin
                e_rw  = RegWr_i;
                e_rf  = Rf_i;
                e_ins = Ins_i;
                if (MemtoReg_i == 2'b01)      e_wb = dmem_rdata;
                else if (MemtoReg_i == 2'b10) e_wb = 32'(64'(PC_i) + 64'd4);
                else                          e_wb = AluRes_i;
            end
        end
        #1;
        chk("m_RegWr_o", 32'(RegWr_o), 32'(e_rw));
        chk("m_Rf_o", 32'(Rf_o), 32'(e_rf));
        chk("m_Ins_o", Ins_o, e_ins);
        chk("m_WbData_o", WbData_o, e_wb);
        chk("m_AddrErr_o", 32'(AddrErr_o), 32'(e_err));
    end

    task automatic cyc(input logic rst, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc, input logic mw, input logic [1:0] m2r,
                       input logic rw, input logic [4:0] rf, input logic [31:0] ins,
                       input logic rdy, input logic [31:0] rdata);
        @(negedge clk);
        reset = rst; AluRes_i = alu; WrData_i = wd; PC_i = pc; MemWr_i = mw;
        MemtoReg_i = m2r; RegWr_i = rw; Rf_i = rf; Ins_i = ins;
        dmem_ready = rdy; dmem_rdata = rdata;
    endtask

    task automatic nop(input logic rst);
        cyc(rst, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic after_edge();
        @(posedge clk); #2;
    endtask

    int stalls;

    initial begin
        nop(1'b0);
        nop(1'b0);
        #2;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_wb", WbData_o, 32'h0);
        nop(1'b1);

        // ALU result passes straight through
        cyc(1'b1, 32'h1234, 32'h0, 32'h40, 1'b0, 2'b00, 1'b1, 5'd5, 32'h00A00293, 1'b0, 32'hFFFF_FFFF);
        #2 chk("alu_stall", 32'(Stall_o), 32'h0);
        after_edge();
        chk("alu_wb", WbData_o, 32'h1234);
        chk("alu_rf", 32'(Rf_o), 32'd5);
        chk("alu_rw", 32'(RegWr_o), 32'h1);

        // asynchronous reset clears the MEM/WB register mid-cycle
        #1 reset = 1'b0;
        #1 chk("async_wb", WbData_o, 32'h0);
        chk("async_rw", 32'(RegWr_o), 32'h0);
        nop(1'b1);

        // load with three wait cycles
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h100, 32'h0, 32'h44, 1'b0, 2'b01, 1'b1, 5'd7, 32'h10002383, 1'b0, 32'h1234_5678);
            #2 if (Stall_o) stalls++;
            after_edge();
            chk("ld_bubble_rw", 32'(RegWr_o), 32'h0);
        end
        cyc(1'b1, 32'h100, 32'h0, 32'h44, 1'b0, 2'b01, 1'b1, 5'd7, 32'h10002383, 1'b1, 32'hDEADBEEF);
        #2 chk("ld_done_stall", 32'(Stall_o), 32'h0);
        after_edge();
        chk("ld_wb", WbData_o, 32'hDEADBEEF);
        chk("ld_rf", 32'(Rf_o), 32'd7);
        chk("ld_stalls", 32'(stalls), 32'd3);

        // zero-wait store
        cyc(1'b1, 32'h200, 32'h55AA, 32'h48, 1'b1, 2'b00, 1'b0, 5'd0, 32'h20A02023, 1'b1, 32'h0);
        #2 chk("st_req", 32'(dmem_req), 32'h1);
        chk("st_we", 32'(dmem_we), 32'h1);
        chk("st_wdata", dmem_wdata, 32'h55AA);
        chk("st_stall", 32'(Stall_o), 32'h0);
        after_edge();
        chk("st_rw", 32'(RegWr_o), 32'h0);

        // misaligned load: dropped, one-cycle error pulse
        cyc(1'b1, 32'h102, 32'h0, 32'h4C, 1'b0, 2'b01, 1'b1, 5'd9, 32'h10202483, 1'b1, 32'hCAFE0000);
        #2 chk("mis_req", 32'(dmem_req), 32'h0);
        chk("mis_stall", 32'(Stall_o), 32'h0);
        after_edge();
        chk("mis_err", 32'(AddrErr_o), 32'h1);
        chk("mis_rw", 32'(RegWr_o), 32'h0);
        chk("mis_rf", 32'(Rf_o), 32'h0);
        nop(1'b1);
        after_edge();
        chk("mis_err_end", 32'(AddrErr_o), 32'h0);

        // misaligned store is also dropped
        cyc(1'b1, 32'h201, 32'h77, 32'h50, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0);
        #2 chk("mis_st_req", 32'(dmem_req), 32'h0);
        after_edge();
        chk("mis_st_err", 32'(AddrErr_o), 32'h1);

        // reset while waiting abandons the request
        cyc(1'b1, 32'h300, 32'h0, 32'h54, 1'b0, 2'b01, 1'b1, 5'd3, 32'h30002183, 1'b0, 32'h0);
        after_edge();
        chk("wait_state", 32'(dut.state_q), 32'(ST_WAIT));
        #1 reset = 1'b0;
        #1 chk("wait_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("wait_rst_req", 32'(dmem_req), 32'h0);
        chk("wait_rst_stall", 32'(Stall_o), 32'h0);
        nop(1'b0);
        nop(1'b1);
        after_edge();
        chk("wait_no_cmp", 32'(RegWr_o), 32'h0);

        // jal link value, including wrap-around
        cyc(1'b1, 32'h0, 32'h0, 32'hFFFFFFFC, 1'b0, 2'b10, 1'b1, 5'd1, 32'h008000EF, 1'b0, 32'h0);
        after_edge();
        chk("jal_wrap_wb", WbData_o, 32'h0);
        chk("jal_wrap_rw", 32'(RegWr_o), 32'h1);
        chk("jal_wrap_ins", Ins_o, 32'h008000EF);
        cyc(1'b1, 32'h0, 32'h0, 32'h10, 1'b0, 2'b10, 1'b1, 5'd1, 32'h008000EF, 1'b0, 32'h0);
        after_edge();
        chk("jal_wb", WbData_o, 32'h14);

        // reserved select behaves like ALU
        cyc(1'b1, 32'hABCD, 32'h0, 32'h60, 1'b0, 2'b11, 1'b1, 5'd2, 32'h1, 1'b0, 32'h9999);
        after_edge();
        chk("rsv_wb", WbData_o, 32'hABCD);

        nop(1'b1);
        nop(1'b1);
        @(posedge clk); #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
